mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single byte-wide data memory between the instruction-fetch port and the MEM-stage load/store port of the pipelined core. Each accepted request is sequenced as one (byte) or four (word, big-endian) single-byte memory beats. The arbiter returns assembled read data with a one-cycle done pulse and drives the per-port stall lines that hold PC/IF_ID and the MEM stage.

## Interface
- ADDR_W, 8, byte address width of memory and both request ports

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch byte address; always a word access
- if_rdata  out  32  fetched instruction, registered
- if_done  out  1  one-cycle pulse, fetch complete
- if_stall  out  1  if_req & ~if_done (combinational)
- mem_req  in  1  data request; held until mem_done
- mem_rw  in  1  0 = read, 1 = write
- mem_size  in  1  1 = word, 0 = byte
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  32  store data; byte store uses [7:0]
- mem_rdata  out  32  load data, registered; byte load is zero-extended
- mem_done  out  1  one-cycle pulse, data access complete
- mem_stall  out  1  mem_req & ~mem_done (combinational)
- ram_en  out  1  memory beat enable
- ram_rw  out  1  0 = read, 1 = write
- ram_addr  out  ADDR_W  beat byte address
- ram_wdata  out  8  beat write byte
- ram_rdata  in  8  beat read byte; combinational from ram_addr

## Operation
- FSM states:
  - IDLE: ram_en = 0. Samples requests. On grant: latch the port id, address, rw, size and wdata; clear beat = 0; go to XFER.
  - XFER: ram_en = 1. ram_addr = base + beat. Word base = {addr[ADDR_W-1:2], 2'b00}; low address bits are ignored, so no misaligned access exists. Byte base = addr. The final beat is beat 3 (word) or beat 0 (byte); it leads to RESP, otherwise beat increments.
  - RESP: the granted port's done = 1 for this cycle only, then go to IDLE.
- Byte order is big-endian:
  - beat k carries bits [31-8k -: 8], i.e. beat 0 = [31:24], beat 3 = [7:0].
  - A read beat k writes ram_rdata into the same slice of the granted port's rdata register.
  - A byte read loads [7:0] and clears [31:8].
- ram_rw = latched rw during XFER. Fetch beats are always reads.
- Arbitration applies in IDLE only:
  - one port requesting: that port is granted;
  - both requesting: MEM wins, unless ARB_RR_EN is defined (see Configuration).
- No preemption: the granted transfer always completes.
- Requests withdrawn mid-transfer:
  - The transfer still completes and done still pulses.
  - The requester ignores the pulse.
- rdata of a port holds its value until that port's next granted read overwrites it. Writes leave mem_rdata unchanged.
- Address arithmetic is ADDR_W bits. Word base 0xFC covers beats 0xFC–0xFF; nothing wraps.
- Reset (asserted at any time, including mid-XFER) forces, asynchronously:
  - state = IDLE, beat = 0, ram_en = 0, ram_rw = 0, ram_addr = 0, ram_wdata = 0;
  - both done = 0, both rdata = 0, last-grant = IF.
- The interrupted transfer is abandoned; no partial-write rollback.

## Timing
- Requests visible in IDLE at cycle t are granted at edge t→t+1.
- Word access: XFER in cycles t+1..t+4; done in t+5; IDLE in t+6.
  - Earliest next grant edge: t+6→t+7, i.e. 6 cycles per word.
- Byte access: XFER in t+1; done in t+2; IDLE in t+3.
- rdata is valid in the done cycle, as the registered result of the last beat.
- Stall lines are combinational:
  - a port with req high stalls every cycle except its done cycle;
  - a port with req low never stalls.

## Configuration
- ARB_RR_EN defined: a 1-bit last-grant register updates on every grant. On contention, the port not granted last wins, so IF and MEM alternate and neither starves.
- ARB_RR_EN undefined: fixed MEM priority and no last-grant register. Fetch may starve under back-to-back stores; this is acceptable because the MEM stage drains.

## Test plan
- Fetch word at 0x04, ram bytes 0xE3,0xA0,0x10,0x05 at 0x04..0x07:
  - ram_addr steps 04,05,06,07;
  - if_done at t+5 with if_rdata = 0xE3A01005;
  - if_stall high t..t+4.
- Store word 0x11223344 to 0x0B:
  - beats at 08..0B with wdata 11,22,33,44 and ram_rw = 1;
  - mem_done at t+5; mem_rdata unchanged.
- Byte load at 0x0A, ram 0x9C:
  - one beat; mem_done at t+2; mem_rdata = 0x0000009C.
- IF and MEM both requesting continuously, 3 rounds:
  - without ARB_RR_EN: grants MEM,MEM,MEM;
  - with ARB_RR_EN: grants MEM,IF,MEM.
- Reset dropped low during beat 2 of a word store:
  - ram_en = 0 immediately, state IDLE, both done = 0;
  - after release, a new fetch starts at beat 0.
- Word access at 0xFE: ram_addr FC,FD,FE,FF; no wrap.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one byte-wide data memory between the instruction-fetch port (IF)
// and the MEM-stage load/store port. Each accepted request becomes one
// (byte) or four (word, big-endian) single-byte memory beats. The granted
// port then gets a one-cycle done pulse, with read data already registered.
//
// Handshake: a port raises req and holds it, with stable attributes, until it
// sees its done pulse. The arbiter samples requests only in IDLE. A grant is
// never preempted. done pulses exactly once per grant. If a requester drops
// req mid-transfer, the transfer still completes and it ignores the pulse.
// stall = req & ~done, so the pipeline holds until the done cycle.
//
// Configuration macro: ARB_RR_EN
//   defined   - round-robin on contention (1-bit last-grant register)
//   undefined - fixed MEM priority
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   if_req/if_addr          fetch request (always a word read)
//   if_rdata/if_done        fetched word and completion pulse
//   if_stall                hold for PC / IF_ID
//   mem_req/rw/size/addr    data request (rw 1 = write, size 1 = word)
//   mem_wdata               store data (byte store uses [7:0])
//   mem_rdata/mem_done      load data (byte zero-extended) and pulse
//   mem_stall               hold for the MEM stage
//   ram_en/rw/addr/wdata    registered memory beat outputs
//   ram_rdata               memory read byte, combinational from ram_addr
//   dbg_state               FSM state (0 IDLE, 1 XFER, 2 RESP)
module mem_port_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic        port_q;   // 1 = MEM port owns the transfer, 0 = IF
  logic        rw_q;
  logic        size_q;
  logic [23:0] wdata_q;  // only the bytes of beats 1..3 are needed later

`ifdef ARB_RR_EN
  logic        last_mem; // 1 = MEM was granted last
`endif

  logic              grant_mem;
  logic [ADDR_W-1:0] g_addr;
  logic [ADDR_W-1:0] g_base;
  logic              g_size;
  logic              g_rw;
  logic [31:0]       g_wdata;
  logic              final_beat;
  logic [31:0]       rd_cur;
  logic [31:0]       rd_next;
  logic [7:0]        wdata_next;

  assign if_stall  = if_req  & ~if_done;
  assign mem_stall = mem_req & ~mem_done;
  assign dbg_state = state;

  always_comb begin
    grant_mem = mem_req;
    if (mem_req && if_req) begin
`ifdef ARB_RR_EN
      grant_mem = ~last_mem;
`else
      grant_mem = 1'b1;
`endif
    end
  end

  // Attributes of the port about to be granted. Fetches are word reads.
  assign g_addr  = grant_mem ? mem_addr  : if_addr;
  assign g_size  = grant_mem ? mem_size  : 1'b1;
  assign g_rw    = grant_mem ? mem_rw    : 1'b0;
  assign g_wdata = grant_mem ? mem_wdata : 32'h0;
  // Word accesses ignore the low address bits, so no access is misaligned.
  assign g_base  = g_size ? {g_addr[ADDR_W-1:2], 2'b00} : g_addr;

  assign final_beat = size_q ? (beat == 2'd3) : 1'b1;

  // Merge the byte returned by the current read beat into the owner's
  // rdata register. Big-endian: beat k fills bits [31-8k -: 8].
  always_comb begin
    rd_cur  = port_q ? mem_rdata : if_rdata;
    rd_next = rd_cur;
    if (!size_q) begin
      rd_next = {24'h0, ram_rdata};
    end else begin
      case (beat)
        2'd0:    rd_next[31:24] = ram_rdata;
        2'd1:    rd_next[23:16] = ram_rdata;
        2'd2:    rd_next[15:8]  = ram_rdata;
        default: rd_next[7:0]   = ram_rdata;
      endcase
    end
  end

  // Write byte for the beat after the current one.
  always_comb begin
    case (beat)
      2'd0:    wdata_next = wdata_q[23:16];
      2'd1:    wdata_next = wdata_q[15:8];
      default: wdata_next = wdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= 2'd0;
      port_q    <= 1'b0;
      rw_q      <= 1'b0;
      size_q    <= 1'b0;
      wdata_q   <= 24'h0;
      ram_en    <= 1'b0;
      ram_rw    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 8'h0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= 32'h0;
      mem_rdata <= 32'h0;
`ifdef ARB_RR_EN
      last_mem  <= 1'b0;
`endif
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || mem_req) begin
            port_q    <= grant_mem;
            rw_q      <= g_rw;
            size_q    <= g_size;
            wdata_q   <= g_wdata[23:0];
            beat      <= 2'd0;
            ram_en    <= 1'b1;
            ram_rw    <= g_rw;
            ram_addr  <= g_base;
            ram_wdata <= g_size ? g_wdata[31:24] : g_wdata[7:0];
`ifdef ARB_RR_EN
            last_mem  <= grant_mem;
`endif
            state     <= XFER;
          end
        end
        XFER: begin
          if (!rw_q) begin
            if (port_q) mem_rdata <= rd_next;
            else        if_rdata  <= rd_next;
          end
          if (final_beat) begin
            ram_en    <= 1'b0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'h0;
            if (port_q) mem_done <= 1'b1;
            else        if_done  <= 1'b1;
            state     <= RESP;
          end else begin
            beat      <= beat + 2'd1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_next;
          end
        end
        RESP: begin
          beat  <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a byte memory model answering the ram_*
// port, a table of directed accesses with fixed expected data, hand-written
// arbitration and mid-transfer reset sequences, and randomized accesses
// checked against a shadow memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        mem_req;
  logic        mem_rw;
  logic        mem_size;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_rw;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] ram [256];
  logic [7:0] init_pat [256];
  logic       preload;

  assign ram_rdata = ram[ram_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_pat[i];
    end else if (ram_en && ram_rw) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_mem [256];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_mem_rd;

  function automatic logic [31:0] model_word(input logic [7:0] b);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) r = (r << 8) | 32'(exp_mem[b + 8'(k)]);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic run_op(input bit is_if, input bit rw, input bit size,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd);
    logic [7:0] a_q[$];
    logic [7:0] w_q[$];
    logic       r_q[$];
    int         lat;
    bit         got;
    bit         stall_bad;
    bit         eff_rw;
    bit         eff_size;
    int         nbeats;
    logic [7:0] base;
    logic [7:0] ba;
    logic [7:0] exp_b;
    logic [31:0] exp_rd;

    eff_rw   = is_if ? 1'b0 : rw;
    eff_size = is_if ? 1'b1 : size;
    nbeats   = eff_size ? 4 : 1;
    base     = eff_size ? (addr & 8'hFC) : addr;

    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_req = 1'b1; mem_rw = rw; mem_size = size;
      mem_addr = addr; mem_wdata = wdata;
    end
    #1;
    stall_bad = is_if ? (if_stall !== 1'b1 || mem_stall !== 1'b0)
                      : (mem_stall !== 1'b1 || if_stall !== 1'b0);
    lat = 0; got = 0; rd = 32'h0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_en === 1'b1) begin
        a_q.push_back(ram_addr); w_q.push_back(ram_wdata); r_q.push_back(ram_rw);
      end
      if ((is_if ? if_done : mem_done) === 1'b1) begin
        got = 1;
        rd = is_if ? if_rdata : mem_rdata;
        if ((is_if ? if_stall : mem_stall) !== 1'b0) stall_bad = 1;
      end else if ((is_if ? if_stall : mem_stall) !== 1'b1) begin
        stall_bad = 1;
      end
      if ((is_if ? mem_stall : if_stall) !== 1'b0) stall_bad = 1;
      if ((is_if ? mem_done : if_done) !== 1'b0) stall_bad = 1;
    end
    if_req = 1'b0; mem_req = 1'b0;

    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), eff_size ? 32'd5 : 32'd2);
    check("stall_done_lines", 32'(stall_bad), 32'd0);
    check("beat_count", 32'(a_q.size()), 32'(nbeats));
    for (int k = 0; k < nbeats && k < a_q.size(); k++) begin
      ba = base + 8'(k);
      check("beat_addr", 32'(a_q[k]), 32'(ba));
      check("beat_rw", 32'(r_q[k]), 32'(eff_rw));
      if (eff_rw) begin
        exp_b = eff_size ? 8'((wdata >> (24 - 8 * k)) & 32'hFF) : wdata[7:0];
        check("beat_wdata", 32'(w_q[k]), 32'(exp_b));
      end
    end

    if (eff_rw) begin
      for (int k = 0; k < nbeats; k++) begin
        ba = base + 8'(k);
        exp_mem[ba] = eff_size ? 8'((wdata >> (24 - 8 * k)) & 32'hFF) : wdata[7:0];
      end
    end else begin
      exp_rd = eff_size ? model_word(base) : {24'h0, exp_mem[base]};
      if (is_if) exp_if_rd = exp_rd;
      else       exp_mem_rd = exp_rd;
    end
    check(is_if ? "if_rdata" : "mem_rdata", rd, is_if ? exp_if_rd : exp_mem_rd);
    check("other_rdata", is_if ? mem_rdata : if_rdata, is_if ? exp_mem_rd : exp_if_rd);

    @(negedge clk);
    check("idle_after", {29'h0, ram_en, dbg_state}, 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          is_if;
    bit          rw;
    bit          size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] rd;
    bit          order [3];
    bit          exp_order [3];
    int          ng;
    int          cyc;
    int          bad;

    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; preload = 1'b0;
    if_req = 1'b0; if_addr = 8'h0;
    mem_req = 1'b0; mem_rw = 1'b0; mem_size = 1'b0;
    mem_addr = 8'h0; mem_wdata = 32'h0;
    exp_if_rd = 32'h0; exp_mem_rd = 32'h0;

    for (int i = 0; i < 256; i++) init_pat[i] = 8'(i * 37 + 11);
    init_pat[8'h04] = 8'hE3; init_pat[8'h05] = 8'hA0;
    init_pat[8'h06] = 8'h10; init_pat[8'h07] = 8'h05;
    init_pat[8'h0A] = 8'h9C;
    init_pat[8'hFC] = 8'hDE; init_pat[8'hFD] = 8'hAD;
    init_pat[8'hFE] = 8'hBE; init_pat[8'hFF] = 8'hEF;
    for (int i = 0; i < 256; i++) exp_mem[i] = init_pat[i];

    //            is_if rw size addr   wdata          exp_rd
    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h04, 32'h0,        32'hE3A01005};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h0A, 32'h0,        32'h0000009C};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h0B, 32'h11223344, 32'h0000009C};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h09, 32'h0,        32'h11223344};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h0A, 32'h0,        32'h00000033};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'hFE, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h20, 32'h123456A5, 32'h00000033};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h20, 32'h0,        32'h000000A5};

    // Reset state and memory preload.
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    check("rst_outputs", {28'h0, ram_en, ram_rw, if_done, mem_done}, 32'h0);
    check("rst_ram_addr", {16'h0, ram_addr, ram_wdata}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_stalls", {30'h0, if_stall, mem_stall}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].is_if, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd);
      check("vec_rdata", vecs[i].is_if ? if_rdata : mem_rdata, vecs[i].exp_rd);
    end

    // Contention: both ports request continuously for three grants.
`ifdef ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1};
`endif
    if_req = 1'b1; if_addr = 8'h04;
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 1'b1; mem_addr = 8'h08;
    ng = 0; cyc = 0;
    while (ng < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (mem_done === 1'b1 && if_done === 1'b1) begin
        check("arb_both_done", 32'h1, 32'h0);
        ng = 3;
      end else if (mem_done === 1'b1) begin
        order[ng] = 1'b1; ng++;
        exp_mem_rd = model_word(8'h08);
        check("arb_mem_rdata", mem_rdata, exp_mem_rd);
      end else if (if_done === 1'b1) begin
        order[ng] = 1'b0; ng++;
        exp_if_rd = model_word(8'h04);
        check("arb_if_rdata", if_rdata, exp_if_rd);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    check("arb_rounds", 32'(ng), 32'd3);
    for (int i = 0; i < 3 && i < ng; i++) check("arb_grant", 32'(order[i]), 32'(exp_order[i]));
    @(negedge clk);
    check("arb_idle", {29'h0, ram_en, dbg_state}, 32'h0);

    // Reset during beat 2 of a word store.
    mem_req = 1'b1; mem_rw = 1'b1; mem_size = 1'b1;
    mem_addr = 8'h40; mem_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ram_en", 32'(ram_en), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    check("mid_rst_done", {30'h0, if_done, mem_done}, 32'h0);
    check("mid_rst_rdata", if_rdata | mem_rdata, 32'h0);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Beats 0 and 1 were written before reset; no rollback.
    exp_mem[8'h40] = 8'hCA;
    exp_mem[8'h41] = 8'hFE;
    exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    run_op(1'b1, 1'b0, 1'b1, 8'h42, 32'h0, rd);

    // Randomized traffic against the shadow model.
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom, rd);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
    check("ram_image", 32'(bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
